// File: rtl/apb_bridge_arb_pkg.sv
// Shared types and constants for the APB bridge arbiter: FSM state encoding
// and the fixed AHB-Lite attribute values driven toward the bridge.
package apb_bridge_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // Index width for a requester count, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_bridge_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick
  import apb_bridge_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W-1:0] base,
                                            input int unsigned off);
    return IDX_W'((32'(base) + off) % NUM_REQ);
  endfunction

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_valid && req[wrap(ptr, k)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = wrap(ptr, k);
      end
    end
  end

endmodule

// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter that serialises single-word requester transactions into
// NONSEQ AHB-Lite transfers on the AHB-to-APB bridge, one outstanding at a time.
module apb_bridge_arbiter
  import apb_bridge_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDRWIDTH = 16,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATAWIDTH-1:0]           rsp_rdata,
  output logic                           rsp_err,
  output logic                           HSEL,
  output logic                           HWRITE,
  output logic [1:0]                     HTRANS,
  output logic [ADDRWIDTH-1:0]           HADDR,
  output logic [DATAWIDTH-1:0]           HWDATA,
  output logic [2:0]                     HSIZE,
  output logic [3:0]                     HPROT,
  output logic                           HREADY,
  input  logic                           HREADYOUT,
  input  logic [DATAWIDTH-1:0]           HRDATA,
  input  logic                           HRESP,
  output logic                           busy
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_e             state, state_nxt;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant;
  logic                   lat_write;
  logic [ADDRWIDTH-1:0]   lat_addr;
  logic [DATAWIDTH-1:0]   lat_wdata;
  logic                   gnt_valid;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   accept;
  logic                   done;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign accept = (state == IDLE) && gnt_valid;
  assign done   = (state == DATA) && HREADYOUT;

  // Single-slave system: the bridge's ready is looped straight back.
  assign HREADY = HREADYOUT;
  assign HSIZE  = HSIZE_WORD;
  assign HPROT  = HPROT_DEFAULT;
  assign HADDR  = lat_addr;
  assign HWDATA = lat_wdata;
  assign HWRITE = lat_write;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_valid) state_nxt = ADDR;
      ADDR:    if (HREADYOUT) state_nxt = DATA;
      DATA:    if (HREADYOUT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus-control decode from the current state.
  always_comb begin
    HSEL      = 1'b0;
    HTRANS    = HTRANS_IDLE;
    busy      = 1'b0;
    req_ready = '0;
    unique case (state)
      IDLE: if (gnt_valid) req_ready = NUM_REQ'(1) << gnt_idx;
      ADDR: begin
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        busy   = 1'b1;
      end
      DATA:    busy = 1'b1;
      default: ;
    endcase
  end

  // Request capture on the handshake edge; read requests carry zero write data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant     <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      grant     <= gnt_idx;
      lat_write <= req_write[gnt_idx];
      lat_addr  <= req_addr[32'(gnt_idx)*ADDRWIDTH +: ADDRWIDTH];
      lat_wdata <= req_write[gnt_idx] ? req_wdata[32'(gnt_idx)*DATAWIDTH +: DATAWIDTH]
                                      : '0;
    end
  end

  // Response registers and pointer rotation on data-phase completion.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      rsp_valid <= '0;
      if (done) begin
        rsp_valid <= NUM_REQ'(1) << grant;
        rsp_rdata <= lat_write ? '0 : HRDATA;
        rsp_err   <= HRESP;
        rr_ptr    <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
      end
    end
  end

endmodule
